// File: rtl/cpu_controller.sv
// Control unit for the single-cycle datapath: instruction decode plus a small
// sequencer for memory stalls, HALT, timeout fault and retired-instruction count.
module cpu_controller #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       code,
    input  logic             ze,
    input  logic             c,
    input  logic             mem_ack,
    output logic             writeReg,
    output logic             memorywrite,
    output logic             memoryread,
    output logic             push,
    output logic             pop,
    output logic             selRR2,
    output logic             selALU2,
    output logic             selpc,
    output logic             selz,
    output logic             selc,
    output logic             ldz,
    output logic             ldc,
    output logic [1:0]       selWD,
    output logic [1:0]       selRet,
    output logic [2:0]       ALUfn,
    output logic             pc_hold,
    output logic             mem_req,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, HALTED} state_t;

    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    state_t           state_r, state_s;
    logic [7:0]       wait_cnt_r, wait_cnt_s;
    logic [8:0]       wait_nxt_s;
    logic [CNT_W-1:0] retired_r;
    logic             halted_r, fault_r;
    logic             retire_s, set_halt_s, set_fault_s;

    logic       d_wr_s, d_mw_s, d_mr_s, d_push_s, d_pop_s, d_rr2_s, d_alu2_s;
    logic       d_selpc_s, d_selz_s, d_selc_s, d_ldz_s, d_ldc_s;
    logic [1:0] d_wd_s, d_ret_s;
    logic [2:0] d_fn_s;
    logic       d_mem_s, d_halt_s;

    assign wait_nxt_s = {1'b0, wait_cnt_r} + 9'd1;
    assign retired    = retired_r;
    assign halted     = halted_r;
    assign fault      = fault_r;

    // Instruction decode, independent of sequencer state
    always_comb begin
        d_wr_s = 1'b0; d_mw_s = 1'b0; d_mr_s = 1'b0; d_push_s = 1'b0; d_pop_s = 1'b0;
        d_rr2_s = 1'b0; d_alu2_s = 1'b0; d_selpc_s = 1'b0; d_selz_s = 1'b0;
        d_selc_s = 1'b0; d_ldz_s = 1'b0; d_ldc_s = 1'b0;
        d_wd_s = 2'b00; d_ret_s = 2'b00; d_fn_s = 3'b000;
        d_mem_s = 1'b0; d_halt_s = 1'b0;
        case (code[5:3])
            3'b000, 3'b001, 3'b010, 3'b011: begin
                d_fn_s   = code[3:1];
                d_alu2_s = ~code[4];
                d_wr_s   = 1'b1;
                d_ldz_s  = 1'b1;
                d_ldc_s  = 1'b1;
            end
            3'b100: begin
                d_mem_s = 1'b1;
                if (code[2]) begin
                    d_rr2_s = 1'b1;
                    d_mw_s  = 1'b1;
                end else begin
                    d_mr_s = 1'b1;
                    d_wd_s = 2'b01;
                end
            end
            3'b101: begin
                d_wd_s   = 2'b10;
                d_wr_s   = 1'b1;
                d_ldz_s  = 1'b1;
                d_ldc_s  = 1'b1;
                d_selz_s = 1'b1;
                d_selc_s = 1'b1;
            end
            3'b110: begin
                case (code[2:0])
                    3'b000:  d_selpc_s = ze;
                    3'b001:  d_selpc_s = ~ze;
                    3'b010:  d_selpc_s = c;
                    3'b011:  d_selpc_s = ~c;
                    default: d_selpc_s = 1'b0;
                endcase
            end
            3'b111: begin
                case (code[2:1])
                    2'b00:   d_ret_s = 2'b10;
                    2'b01: begin
                        d_ret_s  = 2'b10;
                        d_push_s = 1'b1;
                    end
                    2'b10: begin
                        d_ret_s = 2'b01;
                        d_pop_s = 1'b1;
                    end
                    default: d_halt_s = 1'b1;
                endcase
            end
            default: d_halt_s = 1'b0;
        endcase
    end

    // Sequencer next state and gated datapath controls
    always_comb begin
        writeReg = 1'b0; memorywrite = 1'b0; memoryread = 1'b0; push = 1'b0; pop = 1'b0;
        selRR2 = 1'b0; selALU2 = 1'b0; selpc = 1'b0; selz = 1'b0; selc = 1'b0;
        ldz = 1'b0; ldc = 1'b0; selWD = 2'b00; selRet = 2'b00; ALUfn = 3'b000;
        pc_hold = 1'b1; mem_req = 1'b0;
        state_s = state_r; wait_cnt_s = wait_cnt_r;
        retire_s = 1'b0; set_halt_s = 1'b0; set_fault_s = 1'b0;
        case (state_r)
            IDLE: state_s = EXEC;
            EXEC, MEM_WAIT: begin
                if (d_halt_s) begin
                    retire_s   = 1'b1;
                    set_halt_s = 1'b1;
                    state_s    = HALTED;
                end else begin
                    writeReg = d_wr_s; memorywrite = d_mw_s; memoryread = d_mr_s;
                    push = d_push_s; pop = d_pop_s; selRR2 = d_rr2_s; selALU2 = d_alu2_s;
                    selpc = d_selpc_s; selz = d_selz_s; selc = d_selc_s;
                    ldz = d_ldz_s; ldc = d_ldc_s; selWD = d_wd_s; selRet = d_ret_s;
                    ALUfn = d_fn_s;
                    mem_req = d_mem_s;
                    if (!d_mem_s) begin
                        pc_hold  = 1'b0;
                        retire_s = 1'b1;
                    end else if (state_r == EXEC) begin
                        wait_cnt_s = 8'd0;
                        state_s    = MEM_WAIT;
                    end else if (mem_ack) begin
                        // ack takes priority over an expiring timeout
                        writeReg = d_mr_s;
                        pc_hold  = 1'b0;
                        retire_s = 1'b1;
                        state_s  = EXEC;
                    end else if (wait_nxt_s == TIMEOUT_C) begin
                        set_fault_s = 1'b1;
                        state_s     = HALTED;
                    end else begin
                        wait_cnt_s = wait_nxt_s[7:0];
                    end
                end
            end
            HALTED:  state_s = HALTED;
            default: state_s = IDLE;
        endcase
    end

    // State, wait counter, retired count and sticky status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
            retired_r  <= '0;
            halted_r   <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
            if (set_halt_s) begin
                halted_r <= 1'b1;
            end
            if (set_fault_s) begin
                fault_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: decode table in EXEC plus hand-written
// memory-stall, timeout, HALT and reset-abort sequences.
module tb_cpu_controller;

    typedef struct packed {
        logic       wr, mw, mr, push, pop, rr2, alu2, selpc, selz, selc, ldz, ldc;
        logic [1:0] wd;
        logic [1:0] ret;
        logic [2:0] fn;
        logic       hold, req;
    } ctl_t;

    typedef struct {
        string      name;
        logic [5:0] code;
        logic       ze;
        logic       c;
        ctl_t       exp;
    } vec_t;

    logic       clk, rst, ze, c, mem_ack;
    logic [5:0] code;
    logic       writeReg, memorywrite, memoryread, push, pop, selRR2, selALU2;
    logic       selpc, selz, selc, ldz, ldc, pc_hold, mem_req, halted, fault;
    logic [1:0] selWD, selRet;
    logic [2:0] ALUfn;
    logic [3:0] retired;
    ctl_t       act;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_ret;
    vec_t       vecs[18];

    cpu_controller #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .code(code), .ze(ze), .c(c), .mem_ack(mem_ack),
        .writeReg(writeReg), .memorywrite(memorywrite), .memoryread(memoryread),
        .push(push), .pop(pop), .selRR2(selRR2), .selALU2(selALU2), .selpc(selpc),
        .selz(selz), .selc(selc), .ldz(ldz), .ldc(ldc), .selWD(selWD), .selRet(selRet),
        .ALUfn(ALUfn), .pc_hold(pc_hold), .mem_req(mem_req), .halted(halted),
        .fault(fault), .retired(retired)
    );

    assign act = {writeReg, memorywrite, memoryread, push, pop, selRR2, selALU2, selpc,
                  selz, selc, ldz, ldc, selWD, selRet, ALUfn, pc_hold, mem_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string name, input ctl_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: controls got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    localparam ctl_t IDLE_V   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b1,1'b0};
    localparam ctl_t LW_V     = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b1,1'b1};
    localparam ctl_t LW_ACK_V = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0,1'b1};
    localparam ctl_t SW_V     = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b1,1'b1};
    localparam ctl_t SW_ACK_V = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b1};
    localparam ctl_t R1_V     = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,3'b001,1'b0,1'b0};
    localparam ctl_t BT_V     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam ctl_t BN_V     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};

    initial begin
        vecs[0]  = '{"r_fn001",  6'b000010, 1'b0, 1'b0, R1_V};
        vecs[1]  = '{"r_fn111",  6'b001110, 1'b0, 1'b0, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,3'b111,1'b0,1'b0}};
        vecs[2]  = '{"i_fn010",  6'b010100, 1'b0, 1'b0, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,3'b010,1'b0,1'b0}};
        vecs[3]  = '{"i_fn101",  6'b011011, 1'b1, 1'b1, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,3'b101,1'b0,1'b0}};
        vecs[4]  = '{"shift",    6'b101000, 1'b0, 1'b0, '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,2'b10,2'b00,3'b000,1'b0,1'b0}};
        vecs[5]  = '{"bz_taken", 6'b110000, 1'b1, 1'b0, BT_V};
        vecs[6]  = '{"bz_not",   6'b110000, 1'b0, 1'b1, BN_V};
        vecs[7]  = '{"bnz_taken",6'b110001, 1'b0, 1'b0, BT_V};
        vecs[8]  = '{"bnz_not",  6'b110001, 1'b1, 1'b0, BN_V};
        vecs[9]  = '{"bc_taken", 6'b110010, 1'b0, 1'b1, BT_V};
        vecs[10] = '{"bc_not",   6'b110010, 1'b1, 1'b0, BN_V};
        vecs[11] = '{"bnc_taken",6'b110011, 1'b1, 1'b0, BT_V};
        vecs[12] = '{"bnc_not",  6'b110011, 1'b0, 1'b1, BN_V};
        vecs[13] = '{"nop_100",  6'b110100, 1'b1, 1'b1, BN_V};
        vecs[14] = '{"nop_111",  6'b110111, 1'b0, 1'b0, BN_V};
        vecs[15] = '{"jmp",      6'b111000, 1'b0, 1'b0, '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0,1'b0}};
        vecs[16] = '{"jsr",      6'b111010, 1'b0, 1'b0, '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0,1'b0}};
        vecs[17] = '{"ret",      6'b111100, 1'b0, 1'b0, '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,3'b000,1'b0,1'b0}};

        // reset and first R-type instruction
        rst = 1'b0; code = 6'b000010; ze = 1'b0; c = 1'b0; mem_ack = 1'b0;
        #3;
        check_ctl("reset_ctl", IDLE_V);
        check_val("reset_retired", 32'(retired), 32'd0);
        check_val("reset_halted", 32'(halted), 32'd0);
        check_val("reset_fault", 32'(fault), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check_ctl("idle_ctl", IDLE_V);
        step();
        check_ctl("first_exec", R1_V);
        check_val("first_retired0", 32'(retired), 32'd0);
        step();
        check_val("first_retired1", 32'(retired), 32'd1);
        exp_ret = 4'd1;

        // decode table, one EXEC cycle per vector; count wraps at 16
        for (int i = 0; i < 18; i++) begin
            code = vecs[i].code; ze = vecs[i].ze; c = vecs[i].c;
            #1;
            check_ctl(vecs[i].name, vecs[i].exp);
            check_val({vecs[i].name, "_retired"}, 32'(retired), 32'(exp_ret));
            step();
            exp_ret = exp_ret + 4'd1;
        end

        // LW acked on the third wait cycle
        code = 6'b100000;
        #1;
        check_ctl("lw_exec", LW_V);
        step();
        for (int k = 1; k <= 3; k++) begin
            mem_ack = (k == 3) ? 1'b1 : 1'b0;
            #1;
            check_ctl($sformatf("lw_wait%0d", k), (k == 3) ? LW_ACK_V : LW_V);
            check_val($sformatf("lw_wait%0d_retired", k), 32'(retired), 32'(exp_ret));
            step();
        end
        mem_ack = 1'b0;
        exp_ret = exp_ret + 4'd1;

        // SW whose ack coincides with the timeout cycle
        code = 6'b100100;
        #1;
        check_val("lw_done_retired", 32'(retired), 32'(exp_ret));
        check_ctl("sw_exec", SW_V);
        step();
        for (int k = 1; k <= 4; k++) begin
            mem_ack = (k == 4) ? 1'b1 : 1'b0;
            #1;
            check_ctl($sformatf("sw_wait%0d", k), (k == 4) ? SW_ACK_V : SW_V);
            step();
        end
        mem_ack = 1'b0;
        exp_ret = exp_ret + 4'd1;
        #1;
        check_val("sw_ackwins_fault", 32'(fault), 32'd0);
        check_val("sw_ackwins_retired", 32'(retired), 32'(exp_ret));

        // SW with ack only in EXEC: times out after four wait cycles
        mem_ack = 1'b1;
        #1;
        check_ctl("sw2_exec_ack_ignored", SW_V);
        step();
        mem_ack = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check_ctl($sformatf("sw2_wait%0d", k), SW_V);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            mem_ack = k[0];
            #1;
            check_ctl($sformatf("fault_ctl%0d", k), IDLE_V);
            check_val($sformatf("fault_flag%0d", k), 32'(fault), 32'd1);
            check_val($sformatf("fault_halted%0d", k), 32'(halted), 32'd0);
            check_val($sformatf("fault_retired%0d", k), 32'(retired), 32'(exp_ret));
            step();
        end
        mem_ack = 1'b0;

        // HALT after a fresh reset
        rst = 1'b0;
        #1;
        check_val("rst2_retired", 32'(retired), 32'd0);
        check_val("rst2_fault", 32'(fault), 32'd0);
        step();
        code = 6'b111110;
        rst = 1'b1;
        #1;
        check_ctl("rst2_idle", IDLE_V);
        step();
        check_ctl("halt_exec", IDLE_V);
        check_val("halt_exec_halted", 32'(halted), 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            check_ctl($sformatf("halted_ctl%0d", k), IDLE_V);
            check_val($sformatf("halted_flag%0d", k), 32'(halted), 32'd1);
            check_val($sformatf("halted_fault%0d", k), 32'(fault), 32'd0);
            check_val($sformatf("halted_retired%0d", k), 32'(retired), 32'd1);
            step();
        end

        // reset asserted in the middle of a LW wait aborts the access
        rst = 1'b0;
        step();
        code = 6'b100000;
        rst = 1'b1;
        step();
        step();
        #1;
        check_val("abort_pre_req", 32'(mem_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_val("abort_req", 32'(mem_req), 32'd0);
        check_ctl("abort_ctl", IDLE_V);
        check_val("abort_retired", 32'(retired), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Control unit that sits on the opposite side of the single-cycle datapath's `code`/`ze`/`c` interface. It decodes the 6-bit instruction code and the registered zero/carry flags into every datapath select, write and stack strobe. It adds a small sequencer so data-memory accesses can stall on a memory acknowledge, HALT freezes the core, and retired instructions are counted.

## Interface
- TIMEOUT, 15, max MEM_WAIT cycles without `mem_ack` before fault (1..255)
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- code  in  6  instruction bits [18:13]
- ze  in  1  registered zero flag from datapath
- c  in  1  registered carry flag from datapath
- mem_ack  in  1  data memory completed current access
- writeReg, memorywrite, memoryread, push, pop  out  1 each  datapath strobes
- selRR2, selALU2, selpc, selz, selc, ldz, ldc  out  1 each  datapath selects/flag loads
- selWD  out  2  00 ALU, 01 memory, 10 shifter
- selRet  out  2  00 sequential/branch PC, 01 stack top, 10 ins[11:0]
- ALUfn  out  3  ALU function
- pc_hold  out  1  1 = PC must not load this cycle
- mem_req  out  1  data memory access pending
- halted  out  1  core stopped by HALT
- fault  out  1  memory timeout occurred
- retired  out  CNT_W  instructions retired, wraps

## Operation
- Decode (class = code[5:3]):
  - 00x: R-type; ALUfn=code[3:1], selALU2=1, selRR2=0, selWD=00, writeReg, ldz, ldc, selz=selc=0.
  - 01x: I-type; as R-type but selALU2=0.
  - 100, code[2]=0: LW; ALUfn=000, selALU2=0, memoryread, selWD=01, writeReg on completion only.
  - 100, code[2]=1: SW; ALUfn=000, selALU2=0, selRR2=1, memorywrite.
  - 101: shift; selWD=10, writeReg, ldz, ldc, selz=selc=1, ALUfn=000.
  - 110: branch on code[2:0]: 000 BZ (ze), 001 BNZ (!ze), 010 BC (c), 011 BNC (!c); selpc=condition; 1xx = NOP.
  - 111, code[2:1]: 00 JMP (selRet=10); 01 JSR (selRet=10, push); 10 RET (selRet=01, pop); 11 HALT.
- All unlisted outputs 0. Outputs are combinational from state, code, ze, c.
- FSM states: IDLE, EXEC, MEM_WAIT, HALTED.
  - IDLE: entered on reset; all strobes 0, pc_hold=1; next EXEC unconditionally.
  - EXEC, non-memory, non-HALT: decoded controls, pc_hold=0, retired+1, stay.
  - EXEC, LW/SW: mem_req=1, memoryread/memorywrite=1, writeReg=0, pc_hold=1, wait counter cleared → MEM_WAIT.
  - MEM_WAIT: mem_req and the read/write strobe held, ALU/select controls held. On mem_ack: LW asserts writeReg (selWD=01), pc_hold=0, retired+1 → EXEC. Without ack: counter+1; when counter reaches TIMEOUT → HALTED, fault=1.
  - EXEC, HALT: pc_hold=1, retired+1 → HALTED, halted=1.
  - HALTED: all strobes 0, pc_hold=1, mem_req=0. Exit only by reset.
- push/pop/ldz/ldc/writeReg are asserted in exactly one cycle per instruction, the cycle with pc_hold=0.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, counter=0, retired=0, halted=0, fault=0. Combinational outputs are all 0 except pc_hold=1.
- Non-memory instruction: 1 cycle. Memory instruction: 1 + n cycles, where n is the number of MEM_WAIT cycles up to and including the ack cycle (min 2 total).
- mem_ack is ignored outside MEM_WAIT.
- If ack and counter==TIMEOUT occur in the same cycle, ack wins: normal completion, no fault.
- The retired counter wraps from 2^CNT_W−1 to 0.
- Reset mid-MEM_WAIT aborts the access: mem_req drops asynchronously, and no writeReg is issued.
- halted/fault are registered and rise the cycle after the transition into HALTED.

## Test plan
- Reset release with code=000010 (R-type, ALUfn=001) → 1 cycle IDLE (pc_hold=1), then writeReg=1, selALU2=1, ALUfn=001, ldz=ldc=1, pc_hold=0; retired=1 after one EXEC cycle.
- Branches: code=110000, ze=1 → selpc=1; ze=0 → selpc=0. code=110011, c=0 → selpc=1. code=110100 → selpc=0, no strobes.
- LW with ack on 3rd MEM_WAIT cycle → mem_req/memoryread high 4 cycles, pc_hold=1 for first 3 cycles, writeReg=1 with selWD=01 only in the ack cycle, retired+1 exactly once.
- SW with mem_ack pulsed during EXEC then never again, TIMEOUT=4 → ack ignored; after 4 MEM_WAIT cycles enter HALTED; fault=1, halted=0, all strobes 0 thereafter.
- JSR (111010) then RET (111100) → push=1/selRet=10 for one cycle, then pop=1/selRet=01 for one cycle; never both asserted together.
- HALT (111110) → halted=1 next cycle, pc_hold stays 1 indefinitely; rst low mid-MEM_WAIT of a later run → mem_req=0 immediately, retired=0.
